sel_input_decode: RTL and testbench

Readback decoder for the input-channel multiplexer. It samples the board-side feedback of the mux address lines (a2) and group enables (en2), and waits for the pattern to be stable. It then decodes the pattern to an 8-bit physical channel code and flags illegal patterns. It sits on the same PCI register bus as the channel-select register and lets software verify that the commanded channel really reached the mux.

---
 rtl/sel_input_decode.sv | 261 ++++++++++++++++++++++++++
 tb/tb_sel_input_decode.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sel_input_decode.sv
`timescale 1ns / 1ps
// sel_input_decode
//
// Readback decoder for the input-channel multiplexer. It synchronises the board-side feedback of
// the mux address lines (a2) and group enables (en2), waits until the pattern has been stable for
// STABLE_CYC cycles, then decodes it to an 8-bit channel code {group index, a2}. Illegal
// multi-hot enable patterns are flagged. Software reads the result over the PCI register bus to
// confirm that the commanded channel really reached the mux.
//
// Optional feature macro: SEL_DECODE_CMP_EN
//   Defined   : an expected-code register and comparator are built; a decoded code that differs
//               from the expected code while compare is enabled sets mismatch_sticky.
//   Undefined : no comparator; write bits [8:0] are ignored, read bits [13] and [11] are zero.
//
// Ports
//   clk_i                system clock
//   rst_ni               asynchronous active-low reset
//   valid_pci_i          PCI data phase valid
//   rd_wr_i              1 = write, 0 = read
//   ad_to_tuvv_i[31:0]   PCI write data
//   ad_from_tuvv_o[31:0] PCI read data, high-Z unless selected for read
//   data_in_1_dec_sel_i  register select for this block
//   a2_fb_i[3:0]         mux address feedback (asynchronous)
//   en2_fb_i[9:0]        group enable feedback, bit 0 = group 1 (asynchronous)
//   mux_code_o[7:0]      decoded code {group index [7:4], a2 [3:0]}
//   mux_code_valid_o     high while a legal one-hot pattern is decoded
//   mux_fault_o          high while a multi-hot pattern is decoded
//
// Read word layout:
//   [31:22] zero, [21:14] chg_cnt, [13] cmp_en, [12] zero, [11] mismatch_sticky,
//   [10] multihot_sticky, [9:8] state, [7:0] mux_code
// Write word layout:
//   [7:0] expected code, [8] compare enable, [9] clear stickies (pulse), [10] clear chg_cnt

module sel_input_decode #(
    parameter int unsigned STABLE_CYC = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_pci_i,
    input  logic        rd_wr_i,
    input  logic [31:0] ad_to_tuvv_i,
    output logic [31:0] ad_from_tuvv_o,
    input  logic        data_in_1_dec_sel_i,
    input  logic [3:0]  a2_fb_i,
    input  logic [9:0]  en2_fb_i,
    output logic [7:0]  mux_code_o,
    output logic        mux_code_valid_o,
    output logic        mux_fault_o
);

    typedef enum logic [1:0] {
        StOff    = 2'd0,
        StSettle = 2'd1,
        StOn     = 2'd2,
        StFault  = 2'd3
    } state_e;

    localparam logic [7:0] CntLoad = 8'(STABLE_CYC - 1);

    // ------------------------------------------------------------------
    // Input synchroniser and one-cycle-delayed copy for change detection
    // ------------------------------------------------------------------
    logic [13:0] sync1_q;
    logic [13:0] pat_q;
    logic [13:0] pat_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q    <= '0;
            pat_q      <= '0;
            pat_prev_q <= '0;
        end else begin
            sync1_q    <= {en2_fb_i, a2_fb_i};
            pat_q      <= sync1_q;
            pat_prev_q <= pat_q;
        end
    end

    logic [9:0] pat_en;
    logic [3:0] pat_a2;
    logic       pat_changed;

    assign pat_en      = pat_q[13:4];
    assign pat_a2      = pat_q[3:0];
    assign pat_changed = (pat_q != pat_prev_q);

    // Population count of the enables and index of the (last) set bit; the index is only used
    // when exactly one bit is set.
    logic [3:0] en_cnt;
    logic [3:0] grp_idx;

    always_comb begin
        en_cnt  = '0;
        grp_idx = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (pat_en[i]) begin
                en_cnt  = en_cnt + 4'd1;
                grp_idx = 4'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Settle / decode FSM
    // ------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] code_q, code_d;
    logic       valid_q, fault_q;
    logic       chg_inc;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        chg_inc = 1'b0;
        if (pat_changed) begin
            // A change always restarts settling, including on the cycle the count expires.
            state_d = StSettle;
            cnt_d   = CntLoad;
        end else if (state_q == StSettle) begin
            if (cnt_q != 8'd0) begin
                cnt_d = cnt_q - 8'd1;
            end else if (en_cnt == 4'd0) begin
                state_d = StOff;
            end else if (en_cnt == 4'd1) begin
                state_d = StOn;
                code_d  = {grp_idx, pat_a2};
                chg_inc = 1'b1;
            end else begin
                state_d = StFault;
            end
        end
    end

    // valid/fault are registered from the next state so they line up with state_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StOff;
            cnt_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= (state_d == StOn);
            fault_q <= (state_d == StFault);
        end
    end

    assign mux_code_o       = code_q;
    assign mux_code_valid_o = valid_q;
    assign mux_fault_o      = fault_q;

    // ------------------------------------------------------------------
    // PCI register interface
    // ------------------------------------------------------------------
    logic wr_en;
    logic rd_en;
    logic clr_sticky;
    logic clr_chg;

    assign wr_en      = data_in_1_dec_sel_i & valid_pci_i & rd_wr_i;
    assign rd_en      = data_in_1_dec_sel_i & ~rd_wr_i;
    assign clr_sticky = wr_en & ad_to_tuvv_i[9];
    assign clr_chg    = wr_en & ad_to_tuvv_i[10];

    logic [7:0] chg_q, chg_d;
    logic       multihot_q, multihot_d;

    always_comb begin
        chg_d = chg_q;
        if (clr_chg) begin
            chg_d = '0;
        end else if (chg_inc) begin
            chg_d = chg_q + 8'd1;
        end
    end

    // Set has priority over the write-clear.
    always_comb begin
        multihot_d = multihot_q;
        if (state_d == StFault) begin
            multihot_d = 1'b1;
        end else if (clr_sticky) begin
            multihot_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chg_q      <= '0;
            multihot_q <= 1'b0;
        end else begin
            chg_q      <= chg_d;
            multihot_q <= multihot_d;
        end
    end

    logic cmp_en_rd;
    logic mismatch_rd;

`ifdef SEL_DECODE_CMP_EN
    logic [7:0] exp_q, exp_d;
    logic       cmp_en_q, cmp_en_d;
    logic       mismatch_q, mismatch_d;
    logic       mismatch_set;

    // Evaluated from registered state, so the first check lands one cycle after entering ON.
    assign mismatch_set = (state_q == StOn) & cmp_en_q & (code_q != exp_q);

    always_comb begin
        exp_d      = exp_q;
        cmp_en_d   = cmp_en_q;
        mismatch_d = mismatch_q;
        if (wr_en) begin
            exp_d    = ad_to_tuvv_i[7:0];
            cmp_en_d = ad_to_tuvv_i[8];
        end
        if (mismatch_set) begin
            mismatch_d = 1'b1;
        end else if (clr_sticky) begin
            mismatch_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exp_q      <= '0;
            cmp_en_q   <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            exp_q      <= exp_d;
            cmp_en_q   <= cmp_en_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign cmp_en_rd   = cmp_en_q;
    assign mismatch_rd = mismatch_q;

    logic unused_wdata;
    assign unused_wdata = ^ad_to_tuvv_i[31:11];
`else
    assign cmp_en_rd   = 1'b0;
    assign mismatch_rd = 1'b0;

    logic unused_wdata;
    assign unused_wdata = ^{ad_to_tuvv_i[31:11], ad_to_tuvv_i[8:0]};
`endif

    logic [31:0] rd_data;

    assign rd_data = {10'b0, chg_q, cmp_en_rd, 1'b0, mismatch_rd, multihot_q, state_q, code_q};

    assign ad_from_tuvv_o = rd_en ? rd_data : 32'bz;

endmodule

// File: tb/tb_sel_input_decode.sv
`timescale 1ns / 1ps
// Self-checking bench for sel_input_decode: a segment-level reference model predicts every
// decode (code, kind and cycle) into a scoreboard queue; a monitor pops on each rising
// valid/fault and compares. Register reads are compared against the model's view.

module tb_sel_input_decode;

    localparam int unsigned STABLE = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_pci;
    logic        rd_wr;
    logic [31:0] ad_to_tuvv;
    logic [31:0] ad_from_tuvv;
    logic        sel;
    logic [3:0]  a2_fb;
    logic [9:0]  en2_fb;
    logic [7:0]  mux_code;
    logic        mux_code_valid;
    logic        mux_fault;

    sel_input_decode #(
        .STABLE_CYC (STABLE)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .valid_pci_i         (valid_pci),
        .rd_wr_i             (rd_wr),
        .ad_to_tuvv_i        (ad_to_tuvv),
        .ad_from_tuvv_o      (ad_from_tuvv),
        .data_in_1_dec_sel_i (sel),
        .a2_fb_i             (a2_fb),
        .en2_fb_i            (en2_fb),
        .mux_code_o          (mux_code),
        .mux_code_valid_o    (mux_code_valid),
        .mux_fault_o         (mux_fault)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0]  code;
        logic        fault;
        int unsigned cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic prev_v = 1'b0;
    logic prev_f = 1'b0;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ((mux_code_valid && !prev_v) || (mux_fault && !prev_f))) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_decode: got code 0x%02h valid %0b fault %0b, expected none",
                         mux_code, mux_code_valid, mux_fault);
            end else begin
                mon_e = sb_q.pop_front();
                check("decode_code", 32'(mux_code), 32'(mon_e.code));
                check("decode_kind", {30'b0, mux_code_valid, mux_fault},
                      mon_e.fault ? 32'h1 : 32'h2);
                check("decode_cycle", cyc, mon_e.cyc);
            end
        end
        prev_v = mux_code_valid;
        prev_f = mux_fault;
    end

    // ---------------- reference model ----------------
    logic [13:0] m_cur;
    int unsigned m_start;
    bit          m_decided;
    logic [1:0]  m_state;
    logic [7:0]  m_code, m_chg, m_exp;
    bit          m_cmp, m_mism, m_multi;

    task automatic model_reset();
        m_cur = '0; m_start = cyc; m_decided = 1'b1; m_state = 2'd0;
        m_code = '0; m_chg = '0; m_exp = '0; m_cmp = 1'b0; m_mism = 1'b0; m_multi = 1'b0;
    endtask

    // Outcome of a pattern that has been stable long enough.
    task automatic model_decide();
        logic [9:0] en;
        int         ones;
        en   = m_cur[13:4];
        ones = $countones(en);
        m_decided = 1'b1;
        if (ones == 0) begin
            m_state = 2'd0;
        end else if (ones == 1) begin
            for (int i = 0; i < 10; i++) if (en[i]) m_code = {4'(i), m_cur[3:0]};
            m_state = 2'd2;
            m_chg   = m_chg + 8'd1;
`ifdef SEL_DECODE_CMP_EN
            if (m_cmp && m_code != m_exp) m_mism = 1'b1;
`endif
            sb_q.push_back('{code: m_code, fault: 1'b0, cyc: m_start + STABLE + 3});
        end else begin
            m_state = 2'd3;
            m_multi = 1'b1;
            sb_q.push_back('{code: m_code, fault: 1'b1, cyc: m_start + STABLE + 3});
        end
    endtask

    // Drive a pin pattern at a negedge and hold it for h cycles.
    task automatic apply(input logic [9:0] en, input logic [3:0] a2, input int unsigned h);
        logic [13:0] p;
        p = {en, a2};
        @(negedge clk);
        en2_fb = en;
        a2_fb  = a2;
        if (p != m_cur) begin
            m_cur     = p;
            m_start   = cyc;
            m_decided = 1'b0;
        end
        if (!m_decided && (cyc - m_start + h) >= STABLE + 1) model_decide();
        repeat (h - 1) @(negedge clk);
    endtask

    task automatic pci_write(input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; valid_pci = 1'b1; rd_wr = 1'b1; ad_to_tuvv = d;
        @(negedge clk);
        sel = 1'b0; valid_pci = 1'b0; rd_wr = 1'b0; ad_to_tuvv = '0;
        if (d[9]) begin
            m_multi = m_decided && m_state == 2'd3;
`ifdef SEL_DECODE_CMP_EN
            m_mism = m_decided && m_state == 2'd2 && m_cmp && m_code != m_exp;
`endif
        end
`ifdef SEL_DECODE_CMP_EN
        m_exp = d[7:0];
        m_cmp = d[8];
`endif
        if (d[10]) m_chg = '0;
    endtask

    task automatic pci_read_check(input string name);
        logic [31:0] req;
        logic [1:0]  st;
        @(negedge clk);
        sel = 1'b1; rd_wr = 1'b0; valid_pci = 1'b1;
        #1;
        st  = m_decided ? m_state : 2'd1;
        req = {10'b0, m_chg, m_cmp, 1'b0, m_mism, m_multi, st, m_code};
        check(name, ad_from_tuvv, req);
        sel = 1'b0; valid_pci = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    logic [9:0] r_en;
    logic [3:0] r_a2;
    int unsigned r_h;

    initial begin
        rst_n = 1'b0; sel = 1'b0; valid_pci = 1'b0; rd_wr = 1'b0; ad_to_tuvv = '0;
        a2_fb = '0; en2_fb = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_code", 32'(mux_code), 32'h0);
        check("reset_valid_fault", {30'b0, mux_code_valid, mux_fault}, 32'h0);
        rst_n = 1'b1;
        model_reset();
        pci_read_check("reset_read");

        // Clean decode: group 3, a2 = 5 -> 0x25
        apply(10'b00_0000_0100, 4'h5, STABLE + 6);
        pci_read_check("clean_read");
        apply(10'b0, 4'h0, STABLE + 6);
        pci_read_check("off_read");

        // Glitch shorter than the settle window
        apply(10'b00_0000_0001, 4'h0, 10);
        apply(10'b0, 4'h0, STABLE + 6);
        pci_read_check("glitch_read");

        // Multi-hot fault; clear while still faulted loses to the set
        apply(10'b00_0001_0001, 4'h7, STABLE + 6);
        pci_read_check("fault_read");
        pci_write(32'h200);
        pci_read_check("fault_clear_set_wins");
        apply(10'b0, 4'h0, STABLE + 6);
        pci_write(32'h200);
        pci_read_check("fault_cleared");

        // Compare: expect 0x13, land on 0x14, then clear and land on 0x13
        pci_write(32'h113);
        apply(10'b00_0000_0010, 4'h4, STABLE + 6);
        pci_read_check("cmp_mismatch");
        apply(10'b0, 4'h0, STABLE + 6);
        pci_write(32'h313);
        pci_read_check("cmp_cleared");
        apply(10'b00_0000_0010, 4'h3, STABLE + 6);
        pci_read_check("cmp_match");
        pci_write(32'h400);
        pci_read_check("chg_clear");

        // Settle-window boundary: one cycle short, then exactly long enough
        apply(10'b10_0000_0000, 4'hF, STABLE);
        apply(10'b01_0000_0000, 4'h1, STABLE + 1);
        apply(10'b0, 4'h0, STABLE + 6);
        pci_read_check("boundary_read");

        // Asynchronous reset in the middle of settling (counter at 7)
        apply(10'b00_0000_1000, 4'h2, 11);
        pci_read_check("mid_settle_state");
        #1 rst_n = 1'b0;
        #1;
        check("midrst_code", 32'(mux_code), 32'h0);
        check("midrst_valid_fault", {30'b0, mux_code_valid, mux_fault}, 32'h0);
        rst_n = 1'b1;
        model_reset();
        m_cur     = {10'b00_0000_1000, 4'h2};
        m_start   = cyc;
        m_decided = 1'b0;
        check("midrst_queue_empty", sb_q.size(), 32'h0);
        apply(10'b00_0000_1000, 4'h2, STABLE + 6);
        pci_read_check("post_reset_decode");

        // Randomised segments around the settle window
        pci_write(32'h0);
        for (int i = 0; i < 80; i++) begin
            int unsigned k, b0, b1, r;
            k = $urandom_range(0, 3);
            case (k)
                0: r_en = '0;
                1: r_en = 10'(1 << $urandom_range(0, 9));
                2: begin
                    b0   = $urandom_range(0, 9);
                    b1   = (b0 + $urandom_range(1, 9)) % 10;
                    r_en = 10'((1 << b0) | (1 << b1));
                end
                default: r_en = 10'($urandom);
            endcase
            r_a2 = 4'($urandom);
            if ($urandom_range(0, 4) == 0) {r_en, r_a2} = m_cur;
            r = $urandom_range(0, 9);
            if (r < 4)      r_h = $urandom_range(1, STABLE - 1);
            else if (r < 6) r_h = STABLE;
            else if (r < 8) r_h = STABLE + 1;
            else            r_h = $urandom_range(STABLE + 2, STABLE + 10);
            apply(r_en, r_a2, r_h);
        end
        apply(10'b0, 4'h0, STABLE + 6);
        pci_read_check("random_final_read");
        check("queue_drained", sb_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
